// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the MIPS-lite CPU.
// Sequences PC, IR, register file, ALU and data memory; outputs decode from state, op/funct and zero.
module mc_ctrl #(
   parameter int ST_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_wr,
   output logic [1:0] npc_sel,
   output logic       ir_wr,
   output logic       rf_wr,
   output logic       dm_wr,
   output logic [1:0] reg_dst,
   output logic [1:0] wd_sel,
   output logic       alu_src,
   output logic [1:0] ext_op,
   output logic [1:0] alu_op,
   output logic       instr_done
);

   typedef enum logic [ST_W-1:0] {
      FETCH   = ST_W'(0),
      DECODE  = ST_W'(1),
      MEM_ADR = ST_W'(2),
      MEM_RD  = ST_W'(3),
      MEM_WB  = ST_W'(4),
      MEM_WR  = ST_W'(5),
      EXE     = ST_W'(6),
      ALU_WB  = ST_W'(7),
      BRANCH  = ST_W'(8),
      JUMP    = ST_W'(9)
   } state_t;

   state_t r_state;

   logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
   logic w_mem, w_alu, w_jmp;

   assign w_rtype = (op == 6'b000000);
   assign w_addu  = w_rtype && (funct == 6'b100001);
   assign w_subu  = w_rtype && (funct == 6'b100011);
   assign w_jr    = w_rtype && (funct == 6'b001000);
   assign w_ori   = (op == 6'b001101);
   assign w_lui   = (op == 6'b001111);
   assign w_lw    = (op == 6'b100011);
   assign w_sw    = (op == 6'b101011);
   assign w_beq   = (op == 6'b000100);
   assign w_j     = (op == 6'b000010);
   assign w_jal   = (op == 6'b000011);
   assign w_mem   = w_lw || w_sw;
   assign w_alu   = w_addu || w_subu || w_ori || w_lui;
   assign w_jmp   = w_j || w_jal || w_jr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FETCH;
      end else begin
         case (r_state)
            FETCH:   r_state <= DECODE;
            DECODE: begin
               if (w_mem)      r_state <= MEM_ADR;
               else if (w_alu) r_state <= EXE;
               else if (w_beq) r_state <= BRANCH;
               else if (w_jmp) r_state <= JUMP;
               else            r_state <= FETCH;
            end
            MEM_ADR: r_state <= w_lw ? MEM_RD : MEM_WR;
            MEM_RD:  r_state <= MEM_WB;
            EXE:     r_state <= ALU_WB;
            default: r_state <= FETCH;
         endcase
      end
   end

   always_comb begin
      pc_wr      = 1'b0;
      npc_sel    = 2'b00;
      ir_wr      = 1'b0;
      rf_wr      = 1'b0;
      dm_wr      = 1'b0;
      reg_dst    = 2'b00;
      wd_sel     = 2'b00;
      alu_src    = 1'b0;
      ext_op     = 2'b00;
      alu_op     = 2'b00;
      instr_done = 1'b0;
      case (r_state)
         FETCH: begin
            ir_wr = 1'b1;
            pc_wr = 1'b1;
         end
         DECODE: instr_done = !(w_mem || w_alu || w_beq || w_jmp);
         MEM_ADR, MEM_RD: begin
            alu_src = 1'b1;
            ext_op  = 2'b01;
         end
         MEM_WB: begin
            rf_wr      = 1'b1;
            wd_sel     = 2'b01;
            instr_done = 1'b1;
         end
         MEM_WR: begin
            dm_wr      = 1'b1;
            alu_src    = 1'b1;
            ext_op     = 2'b01;
            instr_done = 1'b1;
         end
         EXE, ALU_WB: begin
            // ALU controls held across both states so the result is stable at the write edge
            if (w_subu) alu_op = 2'b01;
            if (w_ori || w_lui) begin
               alu_op  = 2'b10;
               alu_src = 1'b1;
               ext_op  = w_lui ? 2'b10 : 2'b00;
            end
            if (r_state == ALU_WB) begin
               rf_wr      = 1'b1;
               reg_dst    = w_rtype ? 2'b01 : 2'b00;
               instr_done = 1'b1;
            end
         end
         BRANCH: begin
            alu_op     = 2'b01;
            npc_sel    = 2'b01;
            pc_wr      = zero;
            instr_done = 1'b1;
         end
         JUMP: begin
            pc_wr      = 1'b1;
            instr_done = 1'b1;
            npc_sel    = w_jr ? 2'b11 : 2'b10;
            if (w_jal) begin
               rf_wr   = 1'b1;
               reg_dst = 2'b10;
               wd_sel  = 2'b10;
            end
         end
         default: ;
      endcase
      if (rst) begin
         pc_wr      = 1'b0;
         ir_wr      = 1'b0;
         rf_wr      = 1'b0;
         dm_wr      = 1'b0;
         instr_done = 1'b0;
      end
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle control FSM for the MIPS-lite CPU. It sequences the PC register, instruction register, register file, ALU and data memory, one instruction at a time. Each output is a combinational function of the current state, the opcode/funct fields of the IR and the ALU zero flag. The block drives pc_wr and npc_sel into the PC/NPC logic; the PC resets to 0x0000_3000 independently.

Parameters:
ST_W, 4, width of state register

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
op  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, valid in BRANCH state
pc_wr  output  1  PC write enable
npc_sel  output  2  00 PC+4, 01 branch target, 10 jump target (j/jal), 11 register (jr)
ir_wr  output  1  IR write enable
rf_wr  output  1  register file write enable
dm_wr  output  1  data memory write enable
reg_dst  output  2  00 rt, 01 rd, 10 $31
wd_sel  output  2  RF write data: 00 ALU, 01 DM, 10 PC (link)
alu_src  output  1  0 register B, 1 extended immediate
ext_op  output  2  00 zero-ext, 01 sign-ext, 10 imm<<16
alu_op  output  2  00 add, 01 sub, 10 or
instr_done  output  1  one-cycle pulse in the final state of every instruction

Behaviour:
- Supported instructions: addu (R, funct 100001), subu (R, 100011), jr (R, 001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXE 6, ALU_WB 7, BRANCH 8, JUMP 9. Any other encoding goes to FETCH on the next clock.
- rst=1 at a clock edge puts the state in FETCH, regardless of the current state. This includes mid-instruction: no write from the aborted instruction completes after that edge.
- Outputs are not registered. While rst=1, all enables (pc_wr, ir_wr, rf_wr, dm_wr) are forced to 0 and instr_done is 0. All select outputs default to 0 in every state unless listed below.
- FETCH: ir_wr=1, pc_wr=1, npc_sel=00. The PC therefore holds PC+4 from DECODE onward. Next state is DECODE.
- DECODE: no writes.
  - lw/sw -> MEM_ADR.
  - addu/subu/ori/lui -> EXE.
  - beq -> BRANCH.
  - j/jal/jr -> JUMP.
  - Any other op/funct -> FETCH with instr_done=1 (treated as a nop).
- MEM_ADR: alu_src=1, ext_op=01, alu_op=00. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: same ALU controls as MEM_ADR. Next state is MEM_WB.
- MEM_WB: rf_wr=1, reg_dst=00, wd_sel=01, instr_done=1. Next state is FETCH.
- MEM_WR: dm_wr=1, alu_src=1, ext_op=01, instr_done=1. Next state is FETCH.
- EXE and ALU_WB drive identical ALU controls, held stable across both states:
  - addu: alu_op=00, alu_src=0.
  - subu: alu_op=01, alu_src=0.
  - ori: alu_op=10, alu_src=1, ext_op=00.
  - lui: alu_op=10, alu_src=1, ext_op=10.
  - EXE always goes to ALU_WB.
- ALU_WB additionally drives rf_wr=1, wd_sel=00 and instr_done=1. reg_dst=01 for R-type, 00 otherwise. Next state is FETCH.
- BRANCH: alu_op=01, alu_src=0, npc_sel=01, pc_wr=zero, instr_done=1. Next state is FETCH.
- JUMP: pc_wr=1 and instr_done=1.
  - j: npc_sel=10.
  - jal: npc_sel=10, rf_wr=1, reg_dst=10, wd_sel=10. The link value is the PC+4 already in the PC; the RF captures it on the same edge the PC updates.
  - jr: npc_sel=11.
  - Next state is FETCH.
- Latency in cycles from FETCH:
  - R/ori/lui: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jal, jr: 3.
  - Illegal opcode: 2.
- op/funct come from the IR, which is written only in FETCH. They are therefore stable from DECODE to the end of the instruction.

Test Plan:
- Reset: hold rst 2 cycles in any state, then release with IR=addu. Required: the first post-reset cycle is FETCH with ir_wr=1, pc_wr=1, npc_sel=00, and no rf_wr/dm_wr while rst=1.
- addu $3,$1,$2 (op 0, funct 100001). Required: 4-cycle sequence FETCH, DECODE, EXE, ALU_WB; in ALU_WB, rf_wr=1, reg_dst=01, wd_sel=00, alu_op=00, instr_done=1; then FETCH.
- lw then sw. Required: lw takes 5 cycles with rf_wr only in MEM_WB (wd_sel=01, reg_dst=00); sw takes 4 cycles with dm_wr=1 only in MEM_WR; ext_op=01 throughout address states.
- beq with zero=1, then zero=0. Required: BRANCH pc_wr=1 vs 0, npc_sel=01 both times, 3 cycles each.
- jal, then jr (funct 001000). Required: jal JUMP has pc_wr=1, npc_sel=10, rf_wr=1, reg_dst=10, wd_sel=10; jr has npc_sel=11, rf_wr=0.
- Illegal op 111111, then rst asserted in EXE of an ori. Required: the illegal op returns to FETCH after DECODE with instr_done=1 and no writes; ori is aborted with rf_wr never asserted, and the next state is FETCH.
